// File: rtl/output_pingpong_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : output_pingpong_buffer
//  Purpose  : Two-bank ping-pong output buffer for the tensor core. The VPU
//             fills one bank with lane-masked writes and commits it. The read
//             side drains the other bank as a valid/ready stream through a
//             2-entry skid FIFO.
//  Options  : OUTBUF_PARITY_EN - per-lane even parity stored with the data,
//             checked on every read (sticky err_parity)
//  Revision : 1.0 - initial release
// ============================================================================
module output_pingpong_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_LANES  = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data [NUM_LANES],
    input  logic [NUM_LANES-1:0]  wr_lane_mask,
    input  logic                  wr_commit,
    input  logic [ADDR_WIDTH:0]   wr_commit_len,
    output logic                  wr_bank_avail,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data [NUM_LANES],
    output logic                  rd_last,
    output logic [1:0]            banks_free,
    output logic                  err_wr_overflow,
    output logic                  err_parity
);

    localparam int                c_DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] c_ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        B_FREE     = 2'd0,
        B_FILLING  = 2'd1,
        B_FULL     = 2'd2,
        B_DRAINING = 2'd3
    } bank_state_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FLUSH  = 2'd2
    } rd_state_t;

    bank_state_t           r_bank_st  [2];
    logic [ADDR_WIDTH:0]   r_bank_len [2];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_banks_free;
    logic                  r_err_ovf;
    logic                  r_err_par;

    rd_state_t             r_state;
    rd_state_t             w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_rd_addr;

    // Skid FIFO: the SRAM read result lands directly in a FIFO entry
    logic [DATA_WIDTH-1:0] r_fifo_data [2][NUM_LANES];
    logic                  r_fifo_last [2];
    logic                  r_fifo_wp;
    logic                  r_fifo_rp;
    logic [1:0]            r_fifo_cnt;

    logic                  w_wr_acc;
    logic                  w_commit_acc;
    logic [ADDR_WIDTH:0]   w_len_clamped;
    logic                  w_pop;
    logic                  w_room;
    logic                  w_claim;
    logic                  w_issue;
    logic                  w_issue_last;
    logic                  w_done;
    logic                  w_par_any;
    logic [ADDR_WIDTH:0]   w_wr_idx;
    logic [ADDR_WIDTH:0]   w_rd_idx;
    logic [DATA_WIDTH-1:0] w_rd_lane [NUM_LANES];

    assign wr_bank_avail   = (r_bank_st[r_wr_ptr] == B_FREE) || (r_bank_st[r_wr_ptr] == B_FILLING);
    assign w_wr_acc        = wr_en && wr_bank_avail;
    assign w_commit_acc    = wr_commit && wr_bank_avail && (wr_commit_len != '0);
    assign w_len_clamped   = (wr_commit_len > c_MAX_LEN) ? c_MAX_LEN : wr_commit_len;
    assign w_wr_idx        = {r_wr_ptr, wr_addr};
    assign w_rd_idx        = {r_rd_ptr, r_rd_addr};

    assign rd_valid        = (r_fifo_cnt != 2'd0);
    assign rd_last         = rd_valid && r_fifo_last[r_fifo_rp];
    assign w_pop           = rd_valid && rd_ready;
    // Room exists if an entry is free after this cycle's pop
    assign w_room          = (r_fifo_cnt != 2'd2) || w_pop;
    assign w_issue_last    = ({1'b0, r_rd_addr} == (r_bank_len[r_rd_ptr] - c_ONE));

    assign banks_free      = r_banks_free;
    assign err_wr_overflow = r_err_ovf;

    // Output data is the FIFO head entry
    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            rd_data[i] = r_fifo_data[r_fifo_rp][i];
        end
    end

    // Per-lane bank storage; a lane is written only when its mask bit is set
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        logic [DATA_WIDTH-1:0] r_mem [0:2*c_DEPTH-1];

        // Masked synchronous write into the current write bank
        always_ff @(posedge clk) begin
            if (w_wr_acc && wr_lane_mask[gi]) begin
                r_mem[w_wr_idx] <= wr_data[gi];
            end
        end

        assign w_rd_lane[gi] = r_mem[w_rd_idx];
    end

`ifdef OUTBUF_PARITY_EN
    logic [NUM_LANES-1:0] w_par_bad;

    for (genvar gp = 0; gp < NUM_LANES; gp++) begin : g_par
        logic r_par [0:2*c_DEPTH-1];

        // Parity bit follows the lane data: only written lanes refresh it
        always_ff @(posedge clk) begin
            if (w_wr_acc && wr_lane_mask[gp]) begin
                r_par[w_wr_idx] <= ^wr_data[gp];
            end
        end

        assign w_par_bad[gp] = (^w_rd_lane[gp]) ^ r_par[w_rd_idx];
    end

    assign w_par_any = |w_par_bad;
`else
    assign w_par_any = 1'b0;
`endif

    assign err_parity = r_err_par;

    // Bank state machine, pointers, lengths and sticky error flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                r_bank_st[b]  <= B_FREE;
                r_bank_len[b] <= '0;
            end
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_banks_free <= 2'd2;
            r_err_ovf    <= 1'b0;
            r_err_par    <= 1'b0;
        end else begin
            // Read side only touches the bank at the read pointer, which is
            // FULL/DRAINING and therefore never the writable bank
            if (w_claim) begin
                r_bank_st[r_rd_ptr] <= B_DRAINING;
            end
            if (w_done) begin
                r_bank_st[r_rd_ptr] <= B_FREE;
                r_rd_ptr            <= ~r_rd_ptr;
            end
            if (w_wr_acc && (r_bank_st[r_wr_ptr] == B_FREE)) begin
                r_bank_st[r_wr_ptr] <= B_FILLING;
            end
            // Commit overrides FILLING so a same-cycle write joins this bank
            if (w_commit_acc) begin
                r_bank_st[r_wr_ptr]  <= B_FULL;
                r_bank_len[r_wr_ptr] <= w_len_clamped;
                r_wr_ptr             <= ~r_wr_ptr;
            end
            if ((wr_en || wr_commit) && !wr_bank_avail) begin
                r_err_ovf <= 1'b1;
            end
            if (w_issue && w_par_any) begin
                r_err_par <= 1'b1;
            end
            r_banks_free <= {1'b0, (r_bank_st[0] == B_FREE)} + {1'b0, (r_bank_st[1] == B_FREE)};
        end
    end

    // Read FSM state register and drain address counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_rd_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_claim) begin
                r_rd_addr <= '0;
            end else if (w_issue) begin
                r_rd_addr <= r_rd_addr + 1'b1;
            end
        end
    end

    // Read FSM next-state: claim a FULL bank, stream addresses, wait for last
    always_comb begin
        w_state_nxt = r_state;
        w_claim     = 1'b0;
        w_issue     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_bank_st[r_rd_ptr] == B_FULL) begin
                    w_claim     = 1'b1;
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                w_issue = w_room;
                if (w_room && w_issue_last) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (w_pop && rd_last) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Skid FIFO: push on read issue, pop on handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int e = 0; e < 2; e++) begin
                r_fifo_last[e] <= 1'b0;
                for (int i = 0; i < NUM_LANES; i++) begin
                    r_fifo_data[e][i] <= '0;
                end
            end
            r_fifo_wp  <= 1'b0;
            r_fifo_rp  <= 1'b0;
            r_fifo_cnt <= 2'd0;
        end else begin
            if (w_issue) begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    r_fifo_data[r_fifo_wp][i] <= w_rd_lane[i];
                end
                r_fifo_last[r_fifo_wp] <= w_issue_last;
                r_fifo_wp              <= ~r_fifo_wp;
            end
            if (w_pop) begin
                r_fifo_rp <= ~r_fifo_rp;
            end
            r_fifo_cnt <= r_fifo_cnt + {1'b0, w_issue} - {1'b0, w_pop};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_output_pingpong_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_output_pingpong_buffer
//  Purpose  : Directed self-checking bench for output_pingpong_buffer
//  Revision : 1.0 - initial release
// ============================================================================
module tb_output_pingpong_buffer;

    localparam int DW = 32;
    localparam int NL = 16;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data [NL];
    logic [NL-1:0] wr_lane_mask = '1;
    logic          wr_commit = 1'b0;
    logic [AW:0]   wr_commit_len = '0;
    logic          wr_bank_avail;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data [NL];
    logic          rd_last;
    logic [1:0]    banks_free;
    logic          err_wr_overflow;
    logic          err_parity;

    int            n_chk  = 0;
    int            n_pass = 0;
    logic [511:0]  exp_v    [0:1023];
    bit            exp_last [0:1023];
    int            cyc;

    output_pingpong_buffer #(.DATA_WIDTH(DW), .NUM_LANES(NL), .ADDR_WIDTH(AW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .wr_lane_mask    (wr_lane_mask),
        .wr_commit       (wr_commit),
        .wr_commit_len   (wr_commit_len),
        .wr_bank_avail   (wr_bank_avail),
        .rd_valid        (rd_valid),
        .rd_ready        (rd_ready),
        .rd_data         (rd_data),
        .rd_last         (rd_last),
        .banks_free      (banks_free),
        .err_wr_overflow (err_wr_overflow),
        .err_parity      (err_parity)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] pat(input int a, input int off);
        logic [511:0] v;
        for (int i = 0; i < NL; i++) v[i*32 +: 32] = 32'(off + a*16 + i);
        return v;
    endfunction

    function automatic logic [511:0] rd_vec();
        logic [511:0] v;
        for (int i = 0; i < NL; i++) v[i*32 +: 32] = rd_data[i];
        return v;
    endfunction

    task automatic wr(input int a, input logic [511:0] v, input logic [NL-1:0] m,
                      input bit com, input int len);
        wr_en         = 1'b1;
        wr_addr       = AW'(a);
        for (int i = 0; i < NL; i++) wr_data[i] = v[i*32 +: 32];
        wr_lane_mask  = m;
        wr_commit     = com;
        wr_commit_len = (AW+1)'(len);
        tick();
        wr_en     = 1'b0;
        wr_commit = 1'b0;
    endtask

    task automatic commit(input int len);
        wr_commit     = 1'b1;
        wr_commit_len = (AW+1)'(len);
        tick();
        wr_commit = 1'b0;
    endtask

    // Fill addresses 0..n-1 with pat(a,off); optional commit with the last write
    task automatic fill(input int base, input int n, input int off, input bit com);
        for (int a = 0; a < n; a++) begin
            exp_v[base + a] = pat(a, off);
            wr(a, pat(a, off), '1, com && (a == n - 1), n);
        end
    endtask

    task automatic set_last(input int n, input int l0, input int l1);
        for (int k = 0; k < n; k++) exp_last[k] = (k == l0) || (k == l1);
    endtask

    // Consume n beats; mode 0 holds ready high, mode 1 drives ready 1,0,0,...
    task automatic drain(input int n, input int mode, input bit cd, output int c);
        int           beat;
        bit           held_v;
        logic [511:0] held;
        beat   = 0;
        c      = 0;
        held_v = 1'b0;
        held   = '0;
        while (beat < n && c < 4*n + 50) begin
            rd_ready = (mode == 0) ? 1'b1 : (c % 3 == 0);
            if (held_v) begin
                chk("hold_valid", rd_valid, 1);
                chk("hold_data", rd_vec(), held);
            end
            if (rd_valid) begin
                if (cd) chk("beat_data", rd_vec(), exp_v[beat]);
                chk("beat_last", rd_last, exp_last[beat]);
            end
            held_v = rd_valid && !rd_ready;
            held   = rd_vec();
            if (rd_valid && rd_ready) beat++;
            tick();
            c++;
        end
        if (beat != n) chk("drain_timeout", beat, n);
    endtask

    initial begin
        logic [511:0] v;
        for (int i = 0; i < NL; i++) wr_data[i] = '0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        chk("rst_valid", rd_valid, 0);
        chk("rst_last", rd_last, 0);
        chk("rst_data", rd_vec(), 0);
        chk("rst_avail", wr_bank_avail, 1);
        chk("rst_free", banks_free, 2);
        chk("rst_ovf", err_wr_overflow, 0);
        chk("rst_par", err_parity, 0);

        // Zero-length commit is ignored
        commit(0);
        tick();
        tick();
        chk("len0_valid", rd_valid, 0);
        chk("len0_free", banks_free, 2);
        chk("len0_avail", wr_bank_avail, 1);

        // Basic fill of 4; commit shares the cycle with the last write
        fill(0, 4, 0, 1);
        set_last(4, 3, 3);
        chk("t1_lat0", rd_valid, 0);
        tick();
        chk("t1_lat1", rd_valid, 0);
        chk("t1_free_busy", banks_free, 1);
        tick();
        chk("t1_lat2", rd_valid, 1);
        drain(4, 0, 1, cyc);
        chk("t1_cycles", cyc, 4);
        tick();
        chk("t1_free_back", banks_free, 2);
        chk("t1_idle", rd_valid, 0);

        // Lane mask: overwrite only lane 0 of address 5
        fill(0, 5, 32'h100, 0);
        wr(5, pat(5, 32'h100), '1, 0, 0);
        v = '1;
        v[31:0] = 32'hDEAD;
        exp_v[5] = pat(5, 32'h100);
        exp_v[5][31:0] = 32'hDEAD;
        wr(5, v, 16'h0001, 1, 6);
        set_last(6, 5, 5);
        drain(6, 0, 1, cyc);
        tick();
        chk("t2_free", banks_free, 2);

        // Both banks committed, stalled reader: further write is dropped
        rd_ready = 1'b0;
        fill(0, 8, 32'h1000, 1);
        fill(8, 8, 32'h2000, 1);
        chk("t3_avail", wr_bank_avail, 0);
        chk("t3_ovf_pre", err_wr_overflow, 0);
        chk("t3_free0", banks_free, 0);
        wr(0, pat(0, 32'hBAD0), '1, 0, 0);
        chk("t3_ovf", err_wr_overflow, 1);
        chk("t3_avail2", wr_bank_avail, 0);
        // Stalled drain across both banks; dropped write must not show up
        set_last(16, 7, 15);
        drain(16, 1, 1, cyc);
        tick();
        chk("t4_free", banks_free, 2);
        chk("t4_ovf_sticky", err_wr_overflow, 1);

        // Oversized length clamps to the bank depth
        commit(2047);
        set_last(1024, 1023, 1023);
        drain(1024, 0, 0, cyc);
        tick();
        chk("clamp_idle", rd_valid, 0);
        chk("clamp_free", banks_free, 2);

        // Reset in the middle of a drain
        fill(0, 8, 32'h3000, 1);
        rd_ready = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("t5_busy", rd_valid, 1);
        rst_n = 1'b0;
        tick();
        chk("t5_valid", rd_valid, 0);
        chk("t5_free", banks_free, 2);
        chk("t5_avail", wr_bank_avail, 1);
        chk("t5_ovf", err_wr_overflow, 0);
        chk("t5_data", rd_vec(), 0);
        rst_n = 1'b1;
        fill(0, 3, 32'h4000, 1);
        set_last(3, 2, 2);
        drain(3, 0, 1, cyc);
        tick();
        chk("t5_free_after", banks_free, 2);

`ifdef OUTBUF_PARITY_EN
        // Write pointer sits on bank 1 here; corrupt lane 3 of address 1
        fill(0, 2, 32'h5000, 0);
        dut.g_lane[3].r_mem[1025] = dut.g_lane[3].r_mem[1025] ^ 32'h1;
        exp_v[1][96] = ~exp_v[1][96];
        commit(2);
        set_last(2, 1, 1);
        drain(2, 0, 1, cyc);
        chk("par_set", err_parity, 1);
        tick();
        chk("par_sticky", err_parity, 1);
`else
        chk("par_tied", err_parity, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
